cache_tag_ctrl: RTL and testbench

Sequencing controller for the 4-set × 4-way cache tag store. It accepts one lookup request at a time and drives the tag store's read and write strobes, index, way and tag. It qualifies hits with its own per-set valid bits and chooses a victim way on a miss. On a miss it runs a req/ack fill handshake with the memory side, then writes the new tag. It sits between the M-stage request logic and the tag store instance.

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/cache_victim_sel.sv | 24 ++
 rtl/cache_tag_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, types and helpers for the cache tag
// sequencing controller.
//   TAG_W / IDX_W / WAYS  - tag width, set index width, associativity
//   SETS / ADDR_W / RR_W  - derived sizes
//   TAG_LSB / IDX_LSB     - field positions inside a request address {tag, index}
//   state_t               - controller FSM states
//   lowest_onehot()       - isolates the lowest set bit of a way vector
package cache_pkg;

    localparam int TAG_W  = 8;
    localparam int IDX_W  = 2;
    localparam int WAYS   = 4;
    localparam int SETS   = 1 << IDX_W;
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int RR_W   = $clog2(WAYS);

    // Request address layout: {tag, index}, index in the low bits.
    localparam int IDX_LSB = 0;
    localparam int TAG_LSB = IDX_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // One-hot of the lowest set bit; all-zero input gives all-zero output.
    function automatic logic [WAYS-1:0] lowest_onehot(input logic [WAYS-1:0] v);
        logic [WAYS-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: combinational replacement choice for one set.
//   set_valid - valid bits of the addressed set
//   rr        - round-robin pointer of the addressed set
//   victim    - one-hot way to fill
//   used_rr   - 1 when the set was full and the pointer chose the victim
//               (the caller advances the pointer only in that case)
module cache_victim_sel
    import cache_pkg::*;
(
    input  logic [WAYS-1:0] set_valid,
    input  logic [RR_W-1:0] rr,
    output logic [WAYS-1:0] victim,
    output logic            used_rr
);

    always_comb begin
        used_rr = &set_valid;
        victim  = lowest_onehot(~set_valid);
        if (used_rr) begin
            victim = WAYS'(1) << rr;
        end
    end

endmodule

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: sequences one lookup at a time against an external
// 4-set x 4-way tag store, qualifies raw tag matches with its own valid
// bits, and on a miss runs a fill handshake and writes the new tag.
//
// Ports
//   clk, rst                 - clock; synchronous active-low reset
//   req_valid/req_ready      - request handshake, req_addr = {tag, index}
//   inv_all                  - pulse, clears every valid bit (IDLE only)
//   resp_valid/hit/way       - one-cycle response, one-hot way
//   mem_req/mem_ack          - fill handshake with the memory side
//   ts_valid/ts_r/ts_w       - tag store enable and strobes
//   ts_index/ts_way/ts_tag   - tag store set, write way, tag
//   ts_V                     - valid bits of the addressed set (LOOKUP)
//   ts_hit                   - raw one-hot tag match from the tag store
//   dbg_state                - current FSM state, for observation only
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is only ever high in IDLE and never
// depends on req_valid. A fill completes on the first edge in MISS with
// mem_ack=1; mem_req stays high until then and mem_ack is ignored in every
// other state.
module cache_tag_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              inv_all,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAYS-1:0]   resp_way,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              ts_valid,
    output logic              ts_r,
    output logic              ts_w,
    output logic [IDX_W-1:0]  ts_index,
    output logic [WAYS-1:0]   ts_way,
    output logic [TAG_W-1:0]  ts_tag,
    output logic [WAYS-1:0]   ts_V,
    input  logic [WAYS-1:0]   ts_hit,
    output state_t            dbg_state
);

    state_t                       state, state_nxt;
    logic [TAG_W-1:0]             req_tag;
    logic [IDX_W-1:0]             req_idx;
    logic [SETS-1:0][WAYS-1:0]    vbits;
    logic [SETS-1:0][RR_W-1:0]    rr;
    logic [WAYS-1:0]              victim_q;
    logic                         victim_rr_q;
    logic                         resp_hit_q;
    logic [WAYS-1:0]              resp_way_q;

    logic [WAYS-1:0]              set_valid;
    logic [WAYS-1:0]              qual_hit;
    logic [WAYS-1:0]              victim;
    logic                         used_rr;

    assign set_valid = vbits[req_idx];
    // Raw matches from the store may be stale after inv_all or reset;
    // only ways this controller believes valid count as hits.
    assign qual_hit  = ts_hit & set_valid;
    assign dbg_state = state;

    cache_victim_sel u_victim_sel (
        .set_valid (set_valid),
        .rr        (rr[req_idx]),
        .victim    (victim),
        .used_rr   (used_rr)
    );

    // Next state and outputs. Every output is forced low while reset is
    // asserted, so the interface is quiet during reset regardless of state.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_way   = '0;
        mem_req    = 1'b0;
        ts_valid   = 1'b0;
        ts_r       = 1'b0;
        ts_w       = 1'b0;
        ts_index   = '0;
        ts_way     = '0;
        ts_tag     = '0;
        ts_V       = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    // inv_all takes priority over a coincident request.
                    req_ready = !inv_all;
                    if (req_valid && !inv_all) begin
                        state_nxt = LOOKUP;
                    end
                end
                LOOKUP: begin
                    ts_valid  = 1'b1;
                    ts_r      = 1'b1;
                    ts_index  = req_idx;
                    ts_tag    = req_tag;
                    ts_V      = set_valid;
                    state_nxt = (qual_hit != '0) ? RESP : MISS;
                end
                MISS: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    ts_valid  = 1'b1;
                    ts_w      = 1'b1;
                    ts_index  = req_idx;
                    ts_way    = victim_q;
                    ts_tag    = req_tag;
                    state_nxt = RESP;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_hit   = resp_hit_q;
                    resp_way   = resp_way_q;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            req_tag     <= '0;
            req_idx     <= '0;
            vbits       <= '0;
            rr          <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            resp_hit_q  <= 1'b0;
            resp_way_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (inv_all) begin
                        // Replacement pointers intentionally survive.
                        vbits <= '0;
                    end else if (req_valid) begin
                        req_tag <= req_addr[TAG_LSB +: TAG_W];
                        req_idx <= req_addr[IDX_LSB +: IDX_W];
                    end
                end
                LOOKUP: begin
                    if (qual_hit != '0) begin
                        resp_hit_q <= 1'b1;
                        resp_way_q <= lowest_onehot(qual_hit);
                    end else begin
                        victim_q    <= victim;
                        victim_rr_q <= used_rr;
                    end
                end
                FILL: begin
                    vbits[req_idx] <= vbits[req_idx] | victim_q;
                    // Only a full-set eviction advances the pointer.
                    if (victim_rr_q) begin
                        rr[req_idx] <= rr[req_idx] + RR_W'(1);
                    end
                    resp_hit_q <= 1'b0;
                    resp_way_q <= victim_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: directed and randomized lookups against a behavioural
// cache model; a simple tag store memory supplies the raw ts_hit vector.
module tb_cache_tag_ctrl;
    import cache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              inv_all;
    logic              resp_valid;
    logic              resp_hit;
    logic [WAYS-1:0]   resp_way;
    logic              mem_req;
    logic              mem_ack;
    logic              ts_valid;
    logic              ts_r;
    logic              ts_w;
    logic [IDX_W-1:0]  ts_index;
    logic [WAYS-1:0]   ts_way;
    logic [TAG_W-1:0]  ts_tag;
    logic [WAYS-1:0]   ts_V;
    logic [WAYS-1:0]   ts_hit;
    state_t            dbg_state;

    cache_tag_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .inv_all    (inv_all),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .ts_valid   (ts_valid),
        .ts_r       (ts_r),
        .ts_w       (ts_w),
        .ts_index   (ts_index),
        .ts_way     (ts_way),
        .ts_tag     (ts_tag),
        .ts_V       (ts_V),
        .ts_hit     (ts_hit),
        .dbg_state  (dbg_state)
    );

    // ---------------- tag store (never reset, never invalidated) ----------------
    logic [TAG_W-1:0] ts_mem  [SETS][WAYS];
    bit               ts_pres [SETS][WAYS];

    always @(posedge clk) begin
        if (ts_valid && ts_w) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ts_way[w]) begin
                    ts_mem[ts_index][w]  <= ts_tag;
                    ts_pres[ts_index][w] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ts_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            ts_hit[w] = ts_pres[ts_index][w] && (ts_mem[ts_index][w] == ts_tag);
        end
    end

    // ---------------- reference model ----------------
    bit               mv  [SETS][WAYS];
    logic [TAG_W-1:0] mt  [SETS][WAYS];
    int               mrr [SETS];

    function automatic logic [WAYS-1:0] model_valid_vec(input int idx);
        logic [WAYS-1:0] v;
        for (int w = 0; w < WAYS; w++) v[w] = mv[idx][w];
        return v;
    endfunction

    task automatic model_clear_valid();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({req_ready, resp_valid, resp_hit, resp_way, mem_req, ts_valid,
                    ts_r, ts_w, ts_index, ts_way, ts_tag, ts_V});
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the DUT in IDLE; returns at the negedge of the
    // first IDLE cycle after the response (or after reset when rst_in_miss).
    task automatic run_req(input logic [TAG_W-1:0] tag, input int idx, input int ack_delay,
                           input bit with_inv, input bit rst_in_miss);
        bit              hit;
        int              hit_w;
        int              vic_w;
        bit              from_rr;
        logic [WAYS-1:0] exp_v;

        mem_ack = 1'b0;
        if (with_inv) begin
            inv_all   = 1'b1;
            req_valid = 1'b1;
            req_addr  = {tag, IDX_W'(idx)};
            #1;
            check("inv_blocks_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            inv_all = 1'b0;
            model_clear_valid();
            check("inv_no_accept", 32'(ts_valid), 32'd0);
        end

        req_valid = 1'b1;
        req_addr  = {tag, IDX_W'(idx)};
        #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);

        // Expected outcome from the model.
        exp_v = model_valid_vec(idx);
        hit   = 1'b0;
        hit_w = 0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mv[idx][w] && mt[idx][w] == tag) begin
                hit   = 1'b1;
                hit_w = w;
            end
        end

        @(negedge clk);  // LOOKUP
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        mem_ack   = 1'($urandom_range(0, 1));
        check("lookup_rd", 32'({ts_valid, ts_r, ts_w}), 32'b110);
        check("lookup_index", 32'(ts_index), 32'(idx));
        check("lookup_tag", 32'(ts_tag), 32'(tag));
        check("lookup_V", 32'(ts_V), 32'(exp_v));
        check("lookup_busy", 32'({req_ready, resp_valid, mem_req}), 32'd0);

        if (hit) begin
            @(negedge clk);  // RESP
            mem_ack = 1'b0;
            check("hit_resp", 32'({resp_valid, resp_hit}), 32'b11);
            check("hit_way", 32'(resp_way), 32'd1 << hit_w);
            check("hit_quiet", 32'({mem_req, ts_valid, req_ready}), 32'd0);
        end else begin
            vic_w   = -1;
            from_rr = 1'b0;
            for (int w = WAYS - 1; w >= 0; w--) if (!mv[idx][w]) vic_w = w;
            if (vic_w < 0) begin
                vic_w   = mrr[idx];
                from_rr = 1'b1;
            end

            @(negedge clk);  // first MISS cycle
            mem_ack = 1'b0;
            check("miss_mem_req", 32'({mem_req, ts_valid, resp_valid}), 32'b100);

            if (rst_in_miss) begin
                rst = 1'b0;
                @(negedge clk);
                check("rst_outputs_zero", all_outputs(), 32'd0);
                rst = 1'b1;
                model_clear_valid();
                for (int s = 0; s < SETS; s++) mrr[s] = 0;
                #1;
                check("rst_no_resp", 32'({resp_valid, req_ready}), 32'b01);
                return;
            end

            for (int d = 0; d < ack_delay; d++) begin
                @(negedge clk);
                check("miss_hold", 32'(mem_req), 32'd1);
            end
            mem_ack = 1'b1;

            @(negedge clk);  // FILL
            mem_ack = 1'($urandom_range(0, 1));
            check("fill_wr", 32'({ts_valid, ts_r, ts_w, mem_req}), 32'b1010);
            check("fill_way", 32'(ts_way), 32'd1 << vic_w);
            check("fill_tag_idx", 32'({ts_tag, ts_index}), 32'({tag, IDX_W'(idx)}));

            mv[idx][vic_w] = 1'b1;
            mt[idx][vic_w] = tag;
            if (from_rr) mrr[idx] = (mrr[idx] + 1) % WAYS;

            @(negedge clk);  // RESP
            mem_ack = 1'b0;
            check("miss_resp", 32'({resp_valid, resp_hit}), 32'b10);
            check("miss_way", 32'(resp_way), 32'd1 << vic_w);
            check("miss_resp_quiet", 32'({ts_valid, mem_req}), 32'd0);
        end

        @(negedge clk);  // back in IDLE
        check("back_idle", 32'({resp_valid, req_ready, ts_valid}), 32'b010);
    endtask

    task automatic pulse_inv();
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        model_clear_valid();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        inv_all   = 1'b0;
        mem_ack   = 1'b0;
        model_clear_valid();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);
        req_valid = 1'b1;
        inv_all   = 1'b1;
        #1;
        check("reset_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        inv_all   = 1'b0;
        rst       = 1'b1;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // 0x284: tag A1, set 0 -> miss, then hit.
        run_req(8'hA1, 0, 2, 0, 0);
        run_req(8'hA1, 0, 0, 0, 0);

        // Fill all of set 2, then two round-robin evictions.
        for (int t = 1; t <= 6; t++) run_req(TAG_W'(8'hA0 + t), 2, t % 3, 0, 0);
        check("rr_set2_model", 32'(mrr[2]), 32'd2);
        run_req(8'hA3, 2, 0, 0, 0);  // still resident in way 2
        run_req(8'hA1, 2, 0, 0, 0);  // evicted earlier, must miss

        // Stale raw match after invalidate must be treated as a miss.
        pulse_inv();
        run_req(8'hA1, 0, 1, 0, 0);
        // inv_all coincident with a request.
        run_req(8'hB0, 1, 0, 1, 0);

        // Reset while waiting for a fill.
        run_req(8'hC2, 3, 0, 0, 0);
        run_req(8'hC5, 3, 0, 0, 1);
        run_req(8'hC2, 3, 0, 0, 0);

        // Randomized traffic over a small tag pool to mix hits and misses.
        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) pulse_inv();
                else @(negedge clk);
            end
            mem_ack = 1'b0;
            run_req(TAG_W'($urandom_range(16, 23)), $urandom_range(0, SETS - 1),
                    $urandom_range(0, 3), ($urandom_range(0, 19) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
